// File: rtl/fifo_burst_sched_pkg.sv
// fifo_burst_sched_pkg
// Shared definitions for the FIFO burst scheduler: the scheduler state
// encoding and the default FIFO geometry the width constants derive from.
package fifo_burst_sched_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam int LGFLEN_DEF = 4;
  localparam int FLEN_DEF   = 1 << LGFLEN_DEF;
  // Fill/threshold/burst-length fields must hold the value FLEN itself.
  localparam int FILL_W_DEF = LGFLEN_DEF + 1;
  localparam int NBURSTS_W  = 16;

  function automatic int fill_width(input int lgflen);
    return lgflen + 1;
  endfunction

endpackage

// File: rtl/fifo_flush_timer.sv
// fifo_flush_timer
// Idle timer used to flush a partially filled FIFO. Counts up while enabled,
// saturates at all-ones, and reports when the count equals the limit.
// Ports:
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_clear        : zero the count (has priority over i_enable)
//   i_enable       : advance the count by one this cycle
//   i_limit        : flush-timeout value
//   o_expired      : count == i_limit
module fifo_flush_timer #(
  parameter int LGTIMEOUT = 8
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_clear,
  input  logic                 i_enable,
  input  logic [LGTIMEOUT-1:0] i_limit,
  output logic                 o_expired
);

  logic [LGTIMEOUT-1:0] timer;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      timer <= '0;
    end else if (i_enable && (timer != '1)) begin
      timer <= timer + LGTIMEOUT'(1);
    end
  end

  assign o_expired = (timer == i_limit);

endmodule

// File: rtl/fifo_burst_sched.sv
// fifo_burst_sched
// Watches the occupancy of an attached async-read FIFO and drains it as
// valid/ready bursts. A burst starts once the fill reaches the threshold,
// on a forced flush, or (optional) after an idle timeout; its length is
// fixed at start to min(fill, burst_len) so the FIFO can never underflow.
// Optional feature: define FIFO_BURST_SCHED_TIMEOUT_EN to enable the
// partial-flush timeout (i_timeout is ignored otherwise).
// Ports:
//   i_clk, i_reset            : clock, synchronous active-high reset
//   i_empty, i_fill, i_data   : FIFO status and head data
//   o_rd                      : FIFO pop strobe
//   i_threshold, i_burst_len  : start level, max beats (0 means FLEN)
//   i_timeout, i_flush        : idle flush timeout, forced drain
//   o_valid/o_data/o_last     : output stream, i_ready back-pressure
//   o_busy                    : burst in progress
//   o_nbursts                 : completed-burst counter (wraps)
module fifo_burst_sched
  import fifo_burst_sched_pkg::*;
#(
  parameter int BW        = 8,
  parameter int LGFLEN    = LGFLEN_DEF,
  parameter int LGTIMEOUT = 8
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_empty,
  input  logic [LGFLEN:0]      i_fill,
  input  logic [BW-1:0]        i_data,
  output logic                 o_rd,
  input  logic [LGFLEN:0]      i_threshold,
  input  logic [LGFLEN:0]      i_burst_len,
  input  logic [LGTIMEOUT-1:0] i_timeout,
  input  logic                 i_flush,
  output logic                 o_valid,
  output logic [BW-1:0]        o_data,
  output logic                 o_last,
  input  logic                 i_ready,
  output logic                 o_busy,
  output logic [NBURSTS_W-1:0] o_nbursts
);

  localparam int             FW   = fill_width(LGFLEN);
  localparam logic [FW-1:0]  FLEN = {1'b1, {LGFLEN{1'b0}}};

  state_t          state, state_nxt;
  logic [FW-1:0]   remaining, remaining_nxt;
  logic [FW-1:0]   thr_eff, len_eff, beats;
  logic            below_thr, timeout_hit, start, accept;

  assign thr_eff   = (i_threshold == '0) ? FW'(1) : i_threshold;
  assign len_eff   = (i_burst_len == '0) ? FLEN : i_burst_len;
  assign beats     = (i_fill < len_eff) ? i_fill : len_eff;
  assign below_thr = (i_fill < thr_eff);

  // i_fill != 0 guards against an inconsistent FIFO status producing a
  // zero-beat burst that could never terminate.
  assign start = (state == IDLE) && !i_empty && (i_fill != '0) &&
                 (!below_thr || i_flush || timeout_hit);

`ifdef FIFO_BURST_SCHED_TIMEOUT_EN
  logic timer_clear, timer_enable;

  assign timer_clear  = i_empty || start || (state == BURST);
  assign timer_enable = (state == IDLE) && !i_empty && below_thr;

  fifo_flush_timer #(
    .LGTIMEOUT (LGTIMEOUT)
  ) u_flush_timer (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_clear   (timer_clear),
    .i_enable  (timer_enable),
    .i_limit   (i_timeout),
    .o_expired (timeout_hit)
  );
`else
  logic unused_timeout;

  assign unused_timeout = ^i_timeout;
  assign timeout_hit    = 1'b0;
`endif

  assign o_valid = (state == BURST);
  assign o_busy  = (state == BURST);
  assign o_data  = i_data;
  assign o_last  = (state == BURST) && (remaining == FW'(1));
  assign accept  = o_valid && i_ready;
  assign o_rd    = accept;

  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt     = BURST;
          remaining_nxt = beats;
        end
      end
      BURST: begin
        if (accept) begin
          remaining_nxt = remaining - FW'(1);
          if (remaining == FW'(1)) begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt     = IDLE;
        remaining_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= IDLE;
      remaining <= '0;
      o_nbursts <= '0;
    end else begin
      state     <= state_nxt;
      remaining <= remaining_nxt;
      if (accept && o_last) begin
        o_nbursts <= o_nbursts + NBURSTS_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fifo_burst_sched.sv
// tb_fifo_burst_sched
// Directed bench for fifo_burst_sched with a small FIFO model supplying
// i_empty/i_fill/i_data and consuming o_rd pops. Pushed data is a running
// sequence number, so each accepted beat must carry the next number.
// Define FIFO_BURST_SCHED_TIMEOUT_EN for both bench and RTL to cover the
// timeout build.
module tb_fifo_burst_sched;

  logic        i_clk;
  logic        i_reset;
  logic        i_empty;
  logic [4:0]  i_fill;
  logic [7:0]  i_data;
  logic        o_rd;
  logic [4:0]  i_threshold;
  logic [4:0]  i_burst_len;
  logic [7:0]  i_timeout;
  logic        i_flush;
  logic        o_valid;
  logic [7:0]  o_data;
  logic        o_last;
  logic        i_ready;
  logic        o_busy;
  logic [15:0] o_nbursts;

  fifo_burst_sched #(.BW(8), .LGFLEN(4), .LGTIMEOUT(8)) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_empty     (i_empty),
    .i_fill      (i_fill),
    .i_data      (i_data),
    .o_rd        (o_rd),
    .i_threshold (i_threshold),
    .i_burst_len (i_burst_len),
    .i_timeout   (i_timeout),
    .i_flush     (i_flush),
    .o_valid     (o_valid),
    .o_data      (o_data),
    .o_last      (o_last),
    .i_ready     (i_ready),
    .o_busy      (o_busy),
    .o_nbursts   (o_nbursts)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] mem [16];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int fill   = 0;
  int wseq   = 0;
  int rseq   = 0;
  int exp_nb = 0;

  task automatic upd();
    i_fill  = 5'(fill);
    i_empty = (fill == 0);
    i_data  = mem[rd_ptr];
  endtask

  task automatic push(input int n);
    for (int i = 0; i < n; i++) begin
      mem[wr_ptr] = 8'(wseq);
      wr_ptr = (wr_ptr + 1) % 16;
      fill++;
      wseq++;
    end
    upd();
    #1;
  endtask

  // One clock: note whether a pop is being issued, cross the edge, apply the
  // pop to the FIFO model and settle the new inputs.
  task automatic cyc();
    logic pop;
    pop = o_rd;
    @(posedge i_clk);
    #1;
    if (pop === 1'b1) begin
      rd_ptr = (rd_ptr + 1) % 16;
      fill--;
      rseq++;
    end
    upd();
    #1;
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    repeat (3) @(posedge i_clk);
    #2;
    n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", o_valid); end
    n_cmp++; if (o_rd !== 1'b0) begin n_fail++; $display("FAIL reset_rd: got %b want 0", o_rd); end
    n_cmp++; if (o_last !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %b want 0", o_last); end
    n_cmp++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", o_busy); end
    n_cmp++; if (o_nbursts !== 16'd0) begin n_fail++; $display("FAIL reset_nbursts: got %0d want 0", o_nbursts); end
    i_reset = 1'b0;
    cyc();
  endtask

  task automatic test_threshold_burst();
    i_threshold = 5'd4;
    i_burst_len = 5'd4;
    for (int k = 1; k <= 3; k++) begin
      push(1);
      cyc();
      n_cmp++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL ramp_busy fill=%0d: got %b want 0", k, o_busy); end
    end
    push(1);
    n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL ramp_decision_valid: got %b want 0", o_valid); end
    cyc();
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid beat %0d: got %b want 1", k, o_valid); end
      n_cmp++; if (o_data !== 8'(rseq)) begin n_fail++; $display("FAIL basic_data beat %0d: got %0h want %0h", k, o_data, 8'(rseq)); end
      n_cmp++; if (o_last !== (k == 3)) begin n_fail++; $display("FAIL basic_last beat %0d: got %b want %b", k, o_last, (k == 3)); end
      n_cmp++; if (o_rd !== 1'b1) begin n_fail++; $display("FAIL basic_rd beat %0d: got %b want 1", k, o_rd); end
      cyc();
    end
    exp_nb++;
    n_cmp++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL basic_end_busy: got %b want 0", o_busy); end
    n_cmp++; if (o_nbursts !== 16'(exp_nb)) begin n_fail++; $display("FAIL basic_nbursts: got %0d want %0d", o_nbursts, exp_nb); end
    n_cmp++; if (fill !== 0) begin n_fail++; $display("FAIL basic_pops: fill left %0d want 0", fill); end
  endtask

  task automatic test_back_to_back();
    i_threshold = 5'd4;
    i_burst_len = 5'd3;
    push(8);
    n_cmp++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL b2b_pre_busy: got %b want 0", o_busy); end
    cyc();
    for (int b = 0; b < 2; b++) begin
      for (int k = 0; k < 3; k++) begin
        n_cmp++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid burst %0d beat %0d: got %b want 1", b, k, o_valid); end
        n_cmp++; if (o_data !== 8'(rseq)) begin n_fail++; $display("FAIL b2b_data burst %0d beat %0d: got %0h want %0h", b, k, o_data, 8'(rseq)); end
        n_cmp++; if (o_last !== (k == 2)) begin n_fail++; $display("FAIL b2b_last burst %0d beat %0d: got %b want %b", b, k, o_last, (k == 2)); end
        cyc();
      end
      exp_nb++;
      n_cmp++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL b2b_gap burst %0d: got %b want 0", b, o_busy); end
      cyc();
    end
    repeat (3) cyc();
    n_cmp++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL b2b_below_thr_busy: got %b want 0", o_busy); end
    n_cmp++; if (fill !== 2) begin n_fail++; $display("FAIL b2b_leftover: fill %0d want 2", fill); end
    n_cmp++; if (o_nbursts !== 16'(exp_nb)) begin n_fail++; $display("FAIL b2b_nbursts: got %0d want %0d", o_nbursts, exp_nb); end
    i_flush = 1'b1;
    cyc();
    i_flush = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_cmp++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL flush_valid beat %0d: got %b want 1", k, o_valid); end
      n_cmp++; if (o_last !== (k == 1)) begin n_fail++; $display("FAIL flush_last beat %0d: got %b want %b", k, o_last, (k == 1)); end
      cyc();
    end
    exp_nb++;
    n_cmp++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL flush_end_busy: got %b want 0", o_busy); end
    n_cmp++; if (fill !== 0) begin n_fail++; $display("FAIL flush_pops: fill left %0d want 0", fill); end
    n_cmp++; if (o_nbursts !== 16'(exp_nb)) begin n_fail++; $display("FAIL flush_nbursts: got %0d want %0d", o_nbursts, exp_nb); end
  endtask

  task automatic test_stall();
    logic pat [7];
    int   acc;
    logic [7:0] held;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    acc = 0;
    i_threshold = 5'd4;
    i_burst_len = 5'd4;
    push(4);
    cyc();
    for (int i = 0; i < 7; i++) begin
      i_ready = pat[i];
      #1;
      held = 8'(rseq);
      n_cmp++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid cyc %0d: got %b want 1", i, o_valid); end
      n_cmp++; if (o_data !== held) begin n_fail++; $display("FAIL stall_data cyc %0d: got %0h want %0h", i, o_data, held); end
      n_cmp++; if (o_rd !== pat[i]) begin n_fail++; $display("FAIL stall_rd cyc %0d: got %b want %b", i, o_rd, pat[i]); end
      n_cmp++; if (o_last !== (acc == 3)) begin n_fail++; $display("FAIL stall_last cyc %0d: got %b want %b", i, o_last, (acc == 3)); end
      if (pat[i]) acc++;
      cyc();
    end
    i_ready = 1'b1;
    #1;
    exp_nb++;
    n_cmp++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL stall_end_busy: got %b want 0", o_busy); end
    n_cmp++; if (fill !== 0) begin n_fail++; $display("FAIL stall_pops: fill left %0d want 0", fill); end
    n_cmp++; if (o_nbursts !== 16'(exp_nb)) begin n_fail++; $display("FAIL stall_nbursts: got %0d want %0d", o_nbursts, exp_nb); end
  endtask

  task automatic test_reset_mid_burst();
    int saved;
    i_threshold = 5'd4;
    i_burst_len = 5'd4;
    push(4);
    cyc();
    n_cmp++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_first_valid: got %b want 1", o_valid); end
    cyc();
    i_reset = 1'b1;
    cyc();
    exp_nb = 0;
    n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b want 0", o_valid); end
    n_cmp++; if (o_rd !== 1'b0) begin n_fail++; $display("FAIL rstmid_rd: got %b want 0", o_rd); end
    n_cmp++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", o_busy); end
    n_cmp++; if (o_nbursts !== 16'd0) begin n_fail++; $display("FAIL rstmid_nbursts: got %0d want 0", o_nbursts); end
    saved = fill;
    i_reset = 1'b0;
    repeat (3) cyc();
    n_cmp++; if (fill !== saved) begin n_fail++; $display("FAIL rstmid_no_pops: fill %0d want %0d", fill, saved); end
    n_cmp++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_after_busy: got %b want 0", o_busy); end
    // The attached FIFO shares the reset in a real system; empty the model.
    fill = 0;
    rd_ptr = wr_ptr;
    rseq = wseq;
    upd();
    cyc();
  endtask

  task automatic test_timeout();
    i_threshold = 5'd8;
    i_timeout   = 8'd10;
    push(2);
`ifdef FIFO_BURST_SCHED_TIMEOUT_EN
    for (int i = 0; i < 10; i++) begin
      cyc();
      n_cmp++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL tmo_wait_busy cyc %0d: got %b want 0", i, o_busy); end
    end
    cyc();
    n_cmp++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL tmo_start_busy: got %b want 1", o_busy); end
`else
    for (int i = 0; i < 30; i++) begin
      cyc();
      n_cmp++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL notmo_busy cyc %0d: got %b want 0", i, o_busy); end
    end
    i_flush = 1'b1;
    cyc();
    i_flush = 1'b0;
`endif
    i_timeout = 8'd255;
    for (int k = 0; k < 2; k++) begin
      n_cmp++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL tmo_valid beat %0d: got %b want 1", k, o_valid); end
      n_cmp++; if (o_data !== 8'(rseq)) begin n_fail++; $display("FAIL tmo_data beat %0d: got %0h want %0h", k, o_data, 8'(rseq)); end
      n_cmp++; if (o_last !== (k == 1)) begin n_fail++; $display("FAIL tmo_last beat %0d: got %b want %b", k, o_last, (k == 1)); end
      cyc();
    end
    exp_nb++;
    n_cmp++; if (o_nbursts !== 16'(exp_nb)) begin n_fail++; $display("FAIL tmo_nbursts: got %0d want %0d", o_nbursts, exp_nb); end
  endtask

  task automatic test_full_burst();
    i_threshold = 5'd0;
    i_burst_len = 5'd0;
    push(16);
    cyc();
    for (int k = 0; k < 16; k++) begin
      if (k == 5) begin
        i_burst_len = 5'd2;
        i_threshold = 5'd9;
        #1;
      end
      n_cmp++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL full_valid beat %0d: got %b want 1", k, o_valid); end
      n_cmp++; if (o_data !== 8'(rseq)) begin n_fail++; $display("FAIL full_data beat %0d: got %0h want %0h", k, o_data, 8'(rseq)); end
      n_cmp++; if (o_last !== (k == 15)) begin n_fail++; $display("FAIL full_last beat %0d: got %b want %b", k, o_last, (k == 15)); end
      cyc();
    end
    exp_nb++;
    n_cmp++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL full_end_busy: got %b want 0", o_busy); end
    n_cmp++; if (fill !== 0) begin n_fail++; $display("FAIL full_pops: fill left %0d want 0", fill); end
    n_cmp++; if (o_nbursts !== 16'(exp_nb)) begin n_fail++; $display("FAIL full_nbursts: got %0d want %0d", o_nbursts, exp_nb); end
    i_threshold = 5'd0;
    i_flush = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_cmp++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL empty_flush_busy cyc %0d: got %b want 0", i, o_busy); end
      n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL empty_flush_valid cyc %0d: got %b want 0", i, o_valid); end
    end
    i_flush = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    i_reset     = 1'b1;
    i_threshold = 5'd4;
    i_burst_len = 5'd4;
    i_timeout   = 8'd255;
    i_flush     = 1'b0;
    i_ready     = 1'b1;
    upd();
    test_reset();
    test_threshold_burst();
    test_back_to_back();
    test_stall();
    test_reset_mid_burst();
    test_timeout();
    test_full_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_burst_sched.md
FIFO_BURST_SCHED -- requirements
Module: fifo_burst_sched

Interface
REQ-001 SHALL have parameter BW, default 8, data width in bits.
REQ-002 SHALL have parameter LGFLEN, default 4, log2 of the depth of the attached FIFO (FLEN=2^LGFLEN).
REQ-003 SHALL have parameter LGTIMEOUT, default 8, width of the flush-timeout value and timer.
REQ-004 SHALL have ports, in order: i_clk in 1 (sole clock); i_reset in 1 (synchronous, active-high reset).
REQ-005 SHALL have FIFO-side ports: i_empty in 1 (FIFO empty); i_fill in LGFLEN+1 (FIFO occupancy); i_data in BW (async-read FIFO head data); o_rd out 1 (FIFO pop strobe).
REQ-006 SHALL have configuration ports: i_threshold in LGFLEN+1 (fill level that starts a burst); i_burst_len in LGFLEN+1 (max beats per burst); i_timeout in LGTIMEOUT (idle cycles before partial flush); i_flush in 1 (force drain of current contents).
REQ-007 SHALL have stream ports: o_valid out 1; o_data out BW; o_last out 1; i_ready in 1; o_busy out 1 (burst in progress); o_nbursts out 16 (completed-burst counter).

Function
REQ-008 SHALL implement states IDLE and BURST; o_busy = (state==BURST).
REQ-009 In IDLE, SHALL enter BURST next cycle when !i_empty and any of: i_fill >= i_threshold; i_flush; timer == i_timeout (timeout build only).
REQ-010 On entry to BURST, SHALL latch beats = min(i_fill, L), L = i_burst_len, with i_burst_len==0 treated as FLEN; comparison at LGFLEN+1 bits, unsigned.
REQ-011 i_threshold==0 SHALL behave as 1; never start a burst while i_empty.
REQ-012 In BURST: o_valid=1, o_data=i_data (combinational), o_rd = o_valid & i_ready, o_last = (remaining==1).
REQ-013 SHALL decrement remaining on each o_valid & i_ready; on the beat with o_last accepted, SHALL return to IDLE and increment o_nbursts (mod 2^16).
REQ-014 o_valid SHALL not drop and o_data SHALL not change while o_valid & !i_ready.
REQ-015 Since beats <= fill at burst start and this block is the only reader, FIFO SHALL never underflow; concurrent FIFO writes SHALL not extend the current burst.
REQ-016 In IDLE, o_valid=0, o_rd=0, o_last=0.
REQ-017 Minimum gap: one IDLE cycle between consecutive bursts (decision latency 1 cycle).
REQ-018 Config inputs SHALL be sampled only in IDLE; changes during BURST SHALL not affect it.

Reset
REQ-019 On i_reset (sync, active-high), SHALL go to IDLE and clear remaining, timer, o_nbursts; o_valid, o_rd, o_last, o_busy = 0 the following cycle.
REQ-020 Reset mid-burst SHALL abandon the burst without further pops; already-popped beats are not replayed.

Configuration
REQ-021 Macro FIFO_BURST_SCHED_TIMEOUT_EN defined: timer counts up in IDLE while !i_empty and below threshold, saturates at 2^LGTIMEOUT-1, clears when i_empty or on BURST entry; timer==i_timeout triggers burst; i_timeout==0 triggers on first non-empty IDLE cycle.
REQ-022 Macro undefined: no timer logic; i_timeout ignored; bursts start only on threshold or i_flush.

Structure
REQ-023 Shared package SHALL hold the state enum (IDLE, BURST) and the FLEN-derived width constants.
REQ-024 Timer SHALL be a sub-module fifo_flush_timer (clear, enable, limit in; expired out); no other sub-modules.

Verification (LGFLEN=4, BW=8)
REQ-025 threshold=4, burst_len=4, fill ramps 0..4, i_ready=1 -> burst starts cycle after fill==4; 4 beats, o_last on 4th, o_nbursts=1.
REQ-026 threshold=4, burst_len=3, fill=8 -> burst 3 beats, one IDLE cycle, second burst 3 beats, then remaining 2 wait below threshold.
REQ-027 Burst of 4 with i_ready toggling 1,0,0,1,1,0,1 -> o_data/o_valid held during stalls; exactly 4 pops; o_last only on 4th accepted beat.
REQ-028 TIMEOUT_EN, threshold=8, timeout=10, fill=2 held -> burst of 2 starts after 10 non-empty IDLE cycles; without macro, no burst.
REQ-029 i_reset asserted on 2nd beat of 4-beat burst -> next cycle o_valid=0, o_rd=0, o_busy=0, o_nbursts=0; no further pops.
REQ-030 threshold=0, burst_len=0, fill=16 -> single 16-beat burst; with i_empty=1, i_flush=1 -> no burst.
